// File: rtl/branch_resolve_queue.sv
// Execute-side branch resolve queue: pairs in-order fetch predictions with execute outcomes,
// reports mispredictions to the predictor and fetch, and flushes younger entries.
// Optional statistics counters are enabled by defining BRQ_STATS_EN.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    output logic                     pred_ready,
    input  logic [AW-1:0]            pred_pc,
    input  logic                     pred_hit,
    input  logic                     pred_taken,
    input  logic [AW-1:0]            pred_target,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [AW-1:0]            res_target,
    output logic                     mispred,
    output logic [AW-1:0]            t_addr,
    output logic [AW-1:0]            upd_target,
    output logic                     redirect_valid,
    output logic [AW-1:0]            redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     res_err,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_mispred
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          hit;
        logic          taken;
        logic [AW-1:0] target;
    } entry_t;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    entry_t        mem_q [DEPTH];
    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          mispred_q, mispred_d;
    logic          redirect_valid_q, redirect_valid_d;
    logic [AW-1:0] t_addr_q, t_addr_d;
    logic [AW-1:0] upd_target_q, upd_target_d;
    logic [AW-1:0] redirect_pc_q, redirect_pc_d;
    logic          res_err_q, res_err_d;

    entry_t head_e;
    logic   push, pop, mis;

    // Pair the head prediction with the outcome and compute next queue/pulse state
    always_comb begin
        head_e           = mem_q[head_q];
        push             = pred_valid && ready_q;
        pop              = (state_q == ST_RUN) && res_valid && (count_q != '0);
        mis              = pop && ((head_e.taken != res_taken) ||
                           (res_taken && (!head_e.hit || (head_e.target != res_target))));
        state_d          = ST_RUN;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        mispred_d        = 1'b0;
        redirect_valid_d = 1'b0;
        t_addr_d         = t_addr_q;
        upd_target_d     = upd_target_q;
        redirect_pc_d    = redirect_pc_q;
        res_err_d        = res_err_q ||
                           ((state_q == ST_RUN) && res_valid && (count_q == '0));
        if (mis) begin
            // Any same-cycle push is younger than the mispredicted branch and is dropped
            state_d          = ST_FLUSH;
            head_d           = tail_q;
            count_d          = '0;
            mispred_d        = 1'b1;
            redirect_valid_d = 1'b1;
            t_addr_d         = head_e.pc;
            upd_target_d     = res_target;
            redirect_pc_d    = res_taken ? res_target : (head_e.pc + AW'(4));
        end else begin
            head_d  = head_q + PW'(pop);
            tail_d  = tail_q + PW'(push);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        ready_d = (state_d == ST_RUN) && (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_RUN;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            ready_q          <= 1'b1;
            mispred_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            t_addr_q         <= '0;
            upd_target_q     <= '0;
            redirect_pc_q    <= '0;
            res_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            ready_q          <= ready_d;
            mispred_q        <= mispred_d;
            redirect_valid_q <= redirect_valid_d;
            t_addr_q         <= t_addr_d;
            upd_target_q     <= upd_target_d;
            redirect_pc_q    <= redirect_pc_d;
            res_err_q        <= res_err_d;
        end
    end

    // Entry storage needs no reset: only slots between head and tail are ever read
    always_ff @(posedge clk) begin
        if (push && !mis) begin
            mem_q[tail_q] <= '{pc: pred_pc, hit: pred_hit, taken: pred_taken, target: pred_target};
        end
    end

`ifdef BRQ_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

    // Saturating event counters
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (pop && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
        if (mis && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mp_q;
`else
    assign stat_branches = 32'd0;
    assign stat_mispred  = 32'd0;
`endif

    assign pred_ready     = ready_q;
    assign mispred        = mispred_q;
    assign redirect_valid = redirect_valid_q;
    assign t_addr         = t_addr_q;
    assign upd_target     = upd_target_q;
    assign redirect_pc    = redirect_pc_q;
    assign count          = count_q;
    assign res_err        = res_err_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=8, AW=32).
// Statistics expectations follow BRQ_STATS_EN when it is defined for the build.
module tb_branch_resolve_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid = 1'b0, pred_hit = 1'b0, pred_taken = 1'b0;
    logic [31:0] pred_pc = '0, pred_target = '0;
    logic        res_valid = 1'b0, res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        pred_ready, mispred, redirect_valid, res_err;
    logic [31:0] t_addr, upd_target, redirect_pc, stat_branches, stat_mispred;
    logic [3:0]  count;

    int n_vec = 0;
    int n_err = 0;

    branch_resolve_queue #(.DEPTH(8), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .mispred(mispred), .t_addr(t_addr), .upd_target(upd_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .count(count), .res_err(res_err),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus at negedge, return 1 time unit after the following posedge
    task automatic step(input logic pv, input logic [31:0] pc, input logic h, input logic tk,
                        input logic [31:0] tg, input logic rv, input logic rtk,
                        input logic [31:0] rtg);
        @(negedge clk);
        pred_valid = pv; pred_pc = pc; pred_hit = h; pred_taken = tk; pred_target = tg;
        res_valid = rv; res_taken = rtk; res_target = rtg;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        pred_valid = 1'b0; res_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_vec++; if (pred_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", pred_ready); end
        n_vec++; if (mispred !== 1'b0 || redirect_valid !== 1'b0 || res_err !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got mp=%b rv=%b err=%b expected 0 0 0", mispred, redirect_valid, res_err); end
        n_vec++; if (t_addr !== 32'h0 || upd_target !== 32'h0 || redirect_pc !== 32'h0) begin
            n_err++; $display("FAIL reset_addrs: got %h %h %h expected zeros", t_addr, upd_target, redirect_pc); end
        n_vec++; if (stat_branches !== 32'h0 || stat_mispred !== 32'h0) begin
            n_err++; $display("FAIL reset_stats: got %0d %0d expected 0 0", stat_branches, stat_mispred); end
    endtask

    task automatic test_correct();
        step(1, 32'h100, 1, 1, 32'h200, 0, 0, 32'h0);
        n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL correct_push_count: got %0d expected 1", count); end
        step(0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h200);
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL correct_pop_count: got %0d expected 0", count); end
        n_vec++; if (mispred !== 1'b0 || redirect_valid !== 1'b0) begin
            n_err++; $display("FAIL correct_no_pulse: got mp=%b rv=%b expected 0 0", mispred, redirect_valid); end
    endtask

    task automatic test_mispred();
        step(1, 32'h104, 0, 0, 32'h0, 0, 0, 32'h0);
        step(0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h300);
        n_vec++; if (mispred !== 1'b1 || redirect_valid !== 1'b1) begin
            n_err++; $display("FAIL mp_pulse: got mp=%b rv=%b expected 1 1", mispred, redirect_valid); end
        n_vec++; if (t_addr !== 32'h104) begin n_err++; $display("FAIL mp_t_addr: got %h expected 104", t_addr); end
        n_vec++; if (upd_target !== 32'h300) begin n_err++; $display("FAIL mp_upd_target: got %h expected 300", upd_target); end
        n_vec++; if (redirect_pc !== 32'h300) begin n_err++; $display("FAIL mp_redirect_pc: got %h expected 300", redirect_pc); end
        n_vec++; if (pred_ready !== 1'b0 || count !== 4'd0) begin
            n_err++; $display("FAIL mp_flush_state: got ready=%b count=%0d expected 0 0", pred_ready, count); end
        // During flush both push and resolve are offered and must be ignored
        step(1, 32'h700, 1, 1, 32'h800, 1, 1, 32'h300);
        n_vec++; if (mispred !== 1'b0 || redirect_valid !== 1'b0) begin
            n_err++; $display("FAIL mp_single_pulse: got mp=%b rv=%b expected 0 0", mispred, redirect_valid); end
        n_vec++; if (res_err !== 1'b0 || count !== 4'd0) begin
            n_err++; $display("FAIL mp_flush_ignore: got err=%b count=%0d expected 0 0", res_err, count); end
        n_vec++; if (pred_ready !== 1'b1 || t_addr !== 32'h104) begin
            n_err++; $display("FAIL mp_after_flush: got ready=%b t_addr=%h expected 1 104", pred_ready, t_addr); end
    endtask

    task automatic test_flush();
        step(1, 32'h108, 1, 1, 32'h400, 0, 0, 32'h0);
        step(1, 32'h10C, 1, 0, 32'h0, 0, 0, 32'h0);
        step(1, 32'h110, 1, 0, 32'h0, 0, 0, 32'h0);
        step(1, 32'h114, 1, 0, 32'h0, 0, 0, 32'h0);
        n_vec++; if (count !== 4'd4) begin n_err++; $display("FAIL flush_fill: got %0d expected 4", count); end
        step(1, 32'h118, 1, 0, 32'h0, 1, 0, 32'h0);
        n_vec++; if (mispred !== 1'b1 || t_addr !== 32'h108) begin
            n_err++; $display("FAIL flush_pulse: got mp=%b t_addr=%h expected 1 108", mispred, t_addr); end
        n_vec++; if (redirect_pc !== 32'h10C) begin n_err++; $display("FAIL flush_redirect_pc: got %h expected 10c", redirect_pc); end
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", count); end
        step(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        n_vec++; if (count !== 4'd0 || pred_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_recover: got count=%0d ready=%b expected 0 1", count, pred_ready); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] exp_tgt;
        for (int i = 0; i < 8; i++)
            step(1, 32'h1000 + 32'(4*i), 1, 1, 32'h1800 + 32'(4*i), 0, 0, 32'h0);
        n_vec++; if (count !== 4'd8 || pred_ready !== 1'b0) begin
            n_err++; $display("FAIL full_state: got count=%0d ready=%b expected 8 0", count, pred_ready); end
        step(1, 32'h2000, 1, 1, 32'h2800, 1, 1, 32'h1800);
        n_vec++; if (count !== 4'd7 || mispred !== 1'b0 || pred_ready !== 1'b1) begin
            n_err++; $display("FAIL full_refuse: got count=%0d mp=%b ready=%b expected 7 0 1", count, mispred, pred_ready); end
        for (int j = 0; j < 8; j++) begin
            exp_tgt = (j < 7) ? 32'h1800 + 32'(4*(j+1)) : 32'h3800;
            step(1, 32'h3000 + 32'(4*j), 1, 1, 32'h3800 + 32'(4*j), 1, 1, exp_tgt);
            n_vec++; if (mispred !== 1'b0 || count !== 4'd7) begin
                n_err++; $display("FAIL wrap_pair%0d: got mp=%b count=%0d expected 0 7", j, mispred, count); end
        end
        step(0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        n_vec++; if (mispred !== 1'b1 || t_addr !== 32'h3004 || redirect_pc !== 32'h3008) begin
            n_err++; $display("FAIL wrap_order: got mp=%b t_addr=%h rpc=%h expected 1 3004 3008", mispred, t_addr, redirect_pc); end
        step(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic test_res_err();
        step(0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h900);
        n_vec++; if (res_err !== 1'b1 || mispred !== 1'b0 || count !== 4'd0) begin
            n_err++; $display("FAIL err_set: got err=%b mp=%b count=%0d expected 1 0 0", res_err, mispred, count); end
        step(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        n_vec++; if (res_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", res_err); end
        apply_reset();
        n_vec++; if (res_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b expected 0", res_err); end
    endtask

    task automatic test_stats();
        logic [31:0] exp_br, exp_mp;
`ifdef BRQ_STATS_EN
        exp_br = 32'd5; exp_mp = 32'd2;
`else
        exp_br = 32'd0; exp_mp = 32'd0;
`endif
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h600 + 32'(4*k), 1, 1, 32'hA00, 0, 0, 32'h0);
            step(0, 32'h0, 0, 0, 32'h0, 1, 1, 32'hA00);
        end
        for (int k = 0; k < 2; k++) begin
            step(1, 32'h700 + 32'(4*k), 1, 1, 32'hB00, 0, 0, 32'h0);
            step(0, 32'h0, 0, 0, 32'h0, 1, 1, 32'hC00);
            n_vec++; if (mispred !== 1'b1) begin n_err++; $display("FAIL stats_mp%0d: got %b expected 1", k, mispred); end
            step(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        end
        n_vec++; if (stat_branches !== exp_br) begin n_err++; $display("FAIL stat_branches: got %0d expected %0d", stat_branches, exp_br); end
        n_vec++; if (stat_mispred !== exp_mp) begin n_err++; $display("FAIL stat_mispred: got %0d expected %0d", stat_mispred, exp_mp); end
    endtask

    task automatic test_reset_mid_flush();
        step(1, 32'h500, 0, 0, 32'h0, 0, 0, 32'h0);
        step(0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h600);
        n_vec++; if (mispred !== 1'b1) begin n_err++; $display("FAIL rmf_pre: got %b expected 1", mispred); end
        apply_reset();
        n_vec++; if (mispred !== 1'b0 || redirect_valid !== 1'b0) begin
            n_err++; $display("FAIL rmf_pulse: got mp=%b rv=%b expected 0 0", mispred, redirect_valid); end
        n_vec++; if (t_addr !== 32'h0 || redirect_pc !== 32'h0 || upd_target !== 32'h0) begin
            n_err++; $display("FAIL rmf_addrs: got %h %h %h expected zeros", t_addr, redirect_pc, upd_target); end
        n_vec++; if (pred_ready !== 1'b1 || count !== 4'd0 || stat_branches !== 32'h0) begin
            n_err++; $display("FAIL rmf_state: got ready=%b count=%0d br=%0d expected 1 0 0", pred_ready, count, stat_branches); end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_mispred();
        test_flush();
        test_full_wrap();
        test_res_err();
        test_stats();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Execute-side counterpart of the fetch branch predictor.
- Buffers each prediction issued at fetch in order, pairs it with the in-order branch outcome from execute, and detects mispredictions.
- On a misprediction it drives the predictor's update interface (mispred, t_addr) and the fetch redirect.
- On a misprediction it also flushes all younger in-flight predictions.

Parameters:
DEPTH, 8, number of in-flight prediction entries (power of two, >=2)
AW, 32, address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset
pred_valid  input  1  fetch presents a prediction for a branch
pred_ready  output  1  queue accepts prediction this cycle
pred_pc  input  AW  branch instruction address
pred_hit  input  1  predictor hit for pred_pc
pred_taken  input  1  predicted direction
pred_target  input  AW  predicted target (meaningful only if hit)
res_valid  input  1  execute resolves the oldest outstanding branch
res_taken  input  1  actual direction
res_target  input  AW  actual target
mispred  output  1  one-cycle pulse to predictor: update entry t_addr
t_addr  output  AW  address of mispredicted branch
upd_target  output  AW  actual target for predictor update
redirect_valid  output  1  one-cycle pulse to fetch
redirect_pc  output  AW  correct next fetch address
count  output  $clog2(DEPTH)+1  occupied entries
res_err  output  1  sticky: resolve arrived with queue empty
stat_branches  output  32  resolved branch count (see Optional Feature)
stat_mispred  output  32  mispredict count (see Optional Feature)

Behaviour:
- Reset (rst=0 at posedge):
  - count=0; head and tail pointers=0; state=RUN.
  - mispred, redirect_valid and res_err are 0; t_addr, upd_target and redirect_pc are 0; statistics are 0.
- Storage and handshake:
  - Circular FIFO; each entry holds {pc, hit, taken, target}.
  - Push when pred_valid && pred_ready.
  - pred_ready = (state==RUN) && (count<DEPTH). pred_ready is low when full, even if a pop occurs the same cycle.
  - Pointers wrap modulo DEPTH.
- Resolve:
  - When res_valid && count>0, the head entry is compared and popped.
  - mispred_cond = (taken != res_taken) || (res_taken && (!hit || target != res_target)).
  - Not-taken vs not-taken is correct regardless of target.
- Latency: all outputs are registered; mispred and redirect_valid assert the cycle after the resolving edge, for exactly one cycle.
  - t_addr = head.pc.
  - upd_target = res_target.
  - redirect_pc = res_taken ? res_target : head.pc+4 (modulo 2^AW).
  - t_addr, upd_target and redirect_pc hold their values until the next mispredict.
- State machine:
  - RUN -> FLUSH on a mispredict resolve. The queue is cleared in that cycle: count=0 and head=tail, and any simultaneous push is discarded because it is younger.
  - FLUSH -> RUN after exactly one cycle.
  - In FLUSH: pred_ready=0; res_valid is ignored and res_err is not set, because execute is squashing.
- Boundaries:
  - Correct resolve with a simultaneous push: count unchanged.
  - res_valid with count==0 in RUN: no pop, no pulse, res_err<=1 until reset.
  - Mispredict on the last entry with no push: queue empty, behaviour identical to the general flush.
  - Reset asserted mid-flush or mid-operation: all state returns to reset values at that edge, and any pending pulse is cancelled.

Optional Feature:
- BRQ_STATS_EN defined:
  - stat_branches increments on every accepted resolve (RUN, count>0).
  - stat_mispred increments on every mispredict.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by reset.
- Not defined: no counter flops; both ports are constant 0.

Test Plan:
- Reset, then push pc=0x100 {hit=1, taken=1, target=0x200}; resolve taken=1 target=0x200 -> no mispred, count 1->0, redirect_valid stays 0.
- Push pc=0x104 predicted not-taken; resolve taken=1 target=0x300 -> next cycle mispred=1, t_addr=0x104, upd_target=0x300, redirect_pc=0x300; pred_ready=0 for one cycle; count=0.
- Push pc=0x108 {hit=1, taken=1, target=0x400}, plus 3 younger entries; resolve taken=0 -> redirect_pc=0x10C, all 4 entries flushed; a push offered in the same cycle is dropped, so count=0 after the flush.
- Push 8 entries -> pred_ready=0 at count=8. Simultaneous resolve (correct) and pred_valid -> push refused, count=7. Then 8 more push/pop pairs -> pointer wrap, correct ordering of pc values.
- res_valid with empty queue -> res_err=1 and remains 1; no mispred pulse. Assert rst=0 -> res_err=0.
- With BRQ_STATS_EN: 5 resolves including 2 mispredicts -> stat_branches=5, stat_mispred=2. Without the macro both read 0.
